// File: rtl/result_reader.sv
// rtl/result_reader.sv - Streams the block sums and grand total out of the shared result memory.
// Optional feature macro RESULT_CHECK_EN: flags a total that differs from the sum of block words.
module result_reader #(
    parameter int NUM_BLOCKS   = 5,
    parameter int BLOCK_STRIDE = 5,
    parameter int SUM_OFFSET   = 4,
    parameter int TOTAL_ADDR   = 31
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ready,
    input  logic [15:0] data_out,
    output logic [4:0]  address,
    output logic        read_en,
    output logic [15:0] res_data,
    output logic [2:0]  res_index,
    output logic        res_valid,
    input  logic        res_accept,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic        check_err
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE_RD, S_PRESENT, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [4:0]  address_q, address_d;
    logic        read_en_q, read_en_d;
    logic [15:0] res_data_q, res_data_d;
    logic [2:0]  res_index_q, res_index_d;
    logic        res_valid_q, res_valid_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        overrun_q, overrun_d;
    logic        ready_d_q;
    logic        trigger;
    logic [2:0]  idx_inc;
    logic [4:0]  next_addr;
`ifdef RESULT_CHECK_EN
    logic [15:0] sum_q, sum_d;
    logic        check_err_q, check_err_d;
`endif

    // Only the rising edge of ready starts a pass, so the 2-cycle flag counts once.
    assign trigger   = ready && !ready_d_q;
    assign idx_inc   = idx_q + 3'd1;
    assign next_addr = (idx_inc == 3'(NUM_BLOCKS)) ? 5'(TOTAL_ADDR)
                     : 5'(SUM_OFFSET + 32'(idx_inc) * BLOCK_STRIDE);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        address_d   = address_q;
        read_en_d   = 1'b0;
        res_data_d  = res_data_q;
        res_index_d = res_index_q;
        res_valid_d = res_valid_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        overrun_d   = overrun_q | (trigger && (state_q != S_IDLE));
`ifdef RESULT_CHECK_EN
        sum_d       = sum_q;
        check_err_d = check_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    state_d   = S_ISSUE_RD;
                    idx_d     = 3'd0;
                    busy_d    = 1'b1;
                    address_d = 5'(SUM_OFFSET);
                    read_en_d = 1'b1;
`ifdef RESULT_CHECK_EN
                    sum_d       = 16'd0;
                    check_err_d = 1'b0;
`endif
                end
            end
            S_ISSUE_RD: begin
                res_data_d  = data_out;
                res_index_d = idx_q;
                res_valid_d = 1'b1;
                state_d     = S_PRESENT;
`ifdef RESULT_CHECK_EN
                if (idx_q < 3'(NUM_BLOCKS)) begin
                    sum_d = sum_q + data_out;
                end else begin
                    check_err_d = (data_out != sum_q);
                end
`endif
            end
            S_PRESENT: begin
                if (res_valid_q && res_accept) begin
                    res_valid_d = 1'b0;
                    if (idx_q < 3'(NUM_BLOCKS)) begin
                        idx_d     = idx_inc;
                        address_d = next_addr;
                        read_en_d = 1'b1;
                        state_d   = S_ISSUE_RD;
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            idx_q       <= 3'd0;
            address_q   <= 5'd0;
            read_en_q   <= 1'b0;
            res_data_q  <= 16'd0;
            res_index_q <= 3'd0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            ready_d_q   <= 1'b0;
`ifdef RESULT_CHECK_EN
            sum_q       <= 16'd0;
            check_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            address_q   <= address_d;
            read_en_q   <= read_en_d;
            res_data_q  <= res_data_d;
            res_index_q <= res_index_d;
            res_valid_q <= res_valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            overrun_q   <= overrun_d;
            ready_d_q   <= ready;
`ifdef RESULT_CHECK_EN
            sum_q       <= sum_d;
            check_err_q <= check_err_d;
`endif
        end
    end

    assign address   = address_q;
    assign read_en   = read_en_q;
    assign res_data  = res_data_q;
    assign res_index = res_index_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign overrun   = overrun_q;
`ifdef RESULT_CHECK_EN
    assign check_err = check_err_q;
`else
    assign check_err = 1'b0;
`endif

endmodule

// File: tb/tb_result_reader.sv
// tb/tb_result_reader.sv - Randomized self-checking bench for result_reader against a stream-level model.
module tb_result_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        ready;
    logic [15:0] data_out;
    logic [4:0]  address;
    logic        read_en;
    logic [15:0] res_data;
    logic [2:0]  res_index;
    logic        res_valid;
    logic        res_accept;
    logic        busy;
    logic        done;
    logic        overrun;
    logic        check_err;

    logic [15:0] mem [32];
    int          vec = 0;
    int          err = 0;
    int          cyc = 0;
    int          t_cyc;
    int          done_cnt;
    int          done_cyc;
    int          first_rd_cyc;
    logic [4:0]  rd_q[$];
    logic [18:0] acc_q[$];
    logic [19:0] held_q[$];

    result_reader dut (
        .clk(clk), .reset(reset), .ready(ready), .data_out(data_out),
        .address(address), .read_en(read_en), .res_data(res_data),
        .res_index(res_index), .res_valid(res_valid), .res_accept(res_accept),
        .busy(busy), .done(done), .overrun(overrun), .check_err(check_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign data_out = mem[address];

    always @(negedge clk) begin
        if (read_en) begin
            rd_q.push_back(address);
            if (first_rd_cyc < 0) first_rd_cyc = cyc;
        end
        if (res_valid && res_accept) acc_q.push_back({res_index, res_data});
        if (res_valid && !res_accept) held_q.push_back({read_en, res_index, res_data});
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [4:0] exp_addr(input int k);
        return (k == 5) ? 5'd31 : 5'(4 + 5 * k);
    endfunction

    function automatic logic exp_check_err();
        logic [15:0] s = 16'd0;
        for (int b = 0; b < 5; b++) s += mem[4 + 5 * b];
`ifdef RESULT_CHECK_EN
        return s != mem[31];
`else
        return 1'b0;
`endif
    endfunction

    task automatic fill_base();
        for (int a = 0; a < 32; a++) mem[a] = 16'($urandom);
        for (int b = 0; b < 5; b++) mem[4 + 5 * b] = 16'(10 * (b + 1));
        mem[31] = 16'd150;
    endtask

    // mode 0: accept tied 1, 1: hold accept 3 cycles at index 2,
    // 2: random accept, 3: re-pulse ready while index 3 is pending
    task automatic run_stream(input int mode);
        int hold = 0;
        int rp = 0;
        rd_q.delete(); acc_q.delete(); held_q.delete();
        done_cnt = 0; done_cyc = -1; first_rd_cyc = -1;
        @(posedge clk); #1;
        res_accept = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        ready = 1'b1;
        t_cyc = cyc;
        @(posedge clk); #1;
        for (int n = 0; n < 300; n++) begin
            @(posedge clk); #1;
            if (n == 0) ready = 1'b0;
            if (done_cnt != 0) break;
            case (mode)
                1: begin
                    if (res_valid && res_index == 3'd2 && hold < 3) begin
                        res_accept = 1'b0; hold++;
                    end else res_accept = 1'b1;
                end
                2: res_accept = 1'($urandom_range(0, 1));
                3: begin
                    res_accept = 1'b1;
                    if (rp == 0 && res_valid && res_index == 3'd3) begin
                        ready = 1'b1; res_accept = 1'b0; rp = 1;
                    end else if (rp == 1) rp = 2;
                    else if (rp == 2) begin
                        ready = 1'b0; rp = 3;
                    end
                end
                default: res_accept = 1'b1;
            endcase
        end
        res_accept = 1'b1;
        ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; ready = 1'b0; res_accept = 1'b0;
        for (int a = 0; a < 32; a++) mem[a] = 16'd0;
        repeat (2) @(posedge clk);
        #1;
        vec++;
        if ({address, read_en, res_data, res_index, res_valid, busy, done, overrun, check_err} !== 32'd0) begin
            err++;
            $display("FAIL reset_outputs: got %h required 0",
                     {address, read_en, res_data, res_index, res_valid, busy, done, overrun, check_err});
        end
        reset = 1'b1;
    endtask

    task automatic test_streams();
        for (int sc = 0; sc < 7; sc++) begin
            int mode;
            logic exp_err;
            fill_base();
            if (sc == 1) mem[31] = 16'd151;
            if (sc == 2) begin
                mem[4] = 16'hFFFF; mem[9] = 16'd1; mem[14] = 16'd0;
                mem[19] = 16'd0; mem[24] = 16'd0; mem[31] = 16'd0;
            end
            if (sc >= 3) for (int a = 0; a < 32; a++) mem[a] = 16'($urandom);
            if (sc == 6) begin
                logic [15:0] s = 16'd0;
                for (int b = 0; b < 5; b++) s += mem[4 + 5 * b];
                mem[31] = s;
            end
            mode = (sc >= 4) ? 2 : 0;
            exp_err = exp_check_err();
            run_stream(mode);
            vec++;
            if (acc_q.size() != 6) begin
                err++; $display("FAIL stream_len sc%0d: got %0d required 6", sc, acc_q.size());
            end
            for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
                vec++;
                if (acc_q[k] !== {3'(k), mem[exp_addr(k)]}) begin
                    err++; $display("FAIL stream_word sc%0d k%0d: got %h required %h", sc, k, acc_q[k], {3'(k), mem[exp_addr(k)]});
                end
            end
            vec++;
            if (rd_q.size() != 6) begin
                err++; $display("FAIL read_count sc%0d: got %0d required 6", sc, rd_q.size());
            end
            for (int k = 0; k < 6 && k < rd_q.size(); k++) begin
                vec++;
                if (rd_q[k] !== exp_addr(k)) begin
                    err++; $display("FAIL read_addr sc%0d k%0d: got %0d required %0d", sc, k, rd_q[k], exp_addr(k));
                end
            end
            vec++;
            if (check_err !== exp_err) begin
                err++; $display("FAIL check_err sc%0d: got %b required %b", sc, check_err, exp_err);
            end
            vec++;
            if (done_cnt != 1 || busy !== 1'b0) begin
                err++; $display("FAIL done_once sc%0d: got done_cnt=%0d busy=%b required 1/0", sc, done_cnt, busy);
            end
            if (mode == 0) begin
                vec++;
                if (first_rd_cyc != t_cyc + 1 || done_cyc != t_cyc + 13) begin
                    err++; $display("FAIL latency sc%0d: got rd@+%0d done@+%0d required +1/+13",
                                    sc, first_rd_cyc - t_cyc, done_cyc - t_cyc);
                end
            end
        end
    endtask

    task automatic test_back_pressure();
        fill_base();
        run_stream(1);
        vec++;
        if (held_q.size() != 3) begin
            err++; $display("FAIL bp_hold_cycles: got %0d required 3", held_q.size());
        end
        for (int k = 0; k < held_q.size(); k++) begin
            vec++;
            if (held_q[k] !== {1'b0, 3'd2, 16'd30}) begin
                err++; $display("FAIL bp_stable k%0d: got %h required %h", k, held_q[k], {1'b0, 3'd2, 16'd30});
            end
        end
        vec++;
        if (acc_q.size() != 6 || rd_q.size() != 6 || acc_q[5] !== {3'd5, 16'd150} || done_cnt != 1) begin
            err++; $display("FAIL bp_resume: got words=%0d reads=%0d done=%0d required 6/6/1",
                            acc_q.size(), rd_q.size(), done_cnt);
        end
    endtask

    task automatic test_overlap();
        fill_base();
        run_stream(3);
        repeat (4) @(posedge clk);
        #1;
        vec++;
        if (overrun !== 1'b1) begin
            err++; $display("FAIL overrun_set: got %b required 1", overrun);
        end
        vec++;
        if (done_cnt != 1 || acc_q.size() != 6 || rd_q.size() != 6 || busy !== 1'b0) begin
            err++; $display("FAIL overlap_stream: got done=%0d words=%0d reads=%0d busy=%b required 1/6/6/0",
                            done_cnt, acc_q.size(), rd_q.size(), busy);
        end
        for (int k = 0; k < 6 && k < acc_q.size(); k++) begin
            vec++;
            if (acc_q[k] !== {3'(k), 16'(10 * (k + 1) + ((k == 5) ? 90 : 0))}) begin
                err++; $display("FAIL overlap_word k%0d: got %h", k, acc_q[k]);
            end
        end
    endtask

    task automatic test_mid_reset();
        bit hit = 0;
        fill_base();
        rd_q.delete(); acc_q.delete(); held_q.delete(); done_cnt = 0;
        @(posedge clk); #1;
        res_accept = 1'b1; ready = 1'b1;
        @(posedge clk); #1;
        for (int n = 0; n < 40 && !hit; n++) begin
            @(posedge clk); #1;
            ready = 1'b0;
            if (res_valid && res_index == 3'd1) begin
                reset = 1'b0; res_accept = 1'b0; hit = 1;
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        vec++;
        if (!hit || {address, read_en, res_data, res_index, res_valid, busy, done, overrun, check_err} !== 32'd0) begin
            err++; $display("FAIL mid_reset_outputs: got hit=%0d %h required 1 and 0", hit,
                            {address, read_en, res_data, res_index, res_valid, busy, done, overrun, check_err});
        end
        res_accept = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        vec++;
        if (done_cnt != 0 || busy !== 1'b0 || acc_q.size() != 1) begin
            err++; $display("FAIL mid_reset_quiet: got done=%0d busy=%b words=%0d required 0/0/1", done_cnt, busy, acc_q.size());
        end
        run_stream(0);
        vec++;
        if (acc_q.size() != 6 || acc_q[0] !== {3'd0, 16'd10} || acc_q[5] !== {3'd5, 16'd150} || done_cnt != 1) begin
            err++; $display("FAIL mid_reset_restart: got words=%0d first=%h done=%0d required 6/%h/1",
                            acc_q.size(), (acc_q.size() > 0) ? acc_q[0] : 19'h0, done_cnt, {3'd0, 16'd10});
        end
    endtask

    initial begin
        test_reset();
        test_streams();
        test_back_pressure();
        test_overlap();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
